// File: rtl/priority_dispatch_arbiter.sv
// Priority dispatch arbiter.
// Each cycle it picks at most one waiting queue head: the highest starved
// level when any level has waited too long, otherwise the highest valid
// level. The task is bound to the lowest-index free core. It then issues a
// registered dispatch command and tracks core occupancy until core_done.
module priority_dispatch_arbiter #(
    parameter int NUM_LEVELS = 4,
    parameter int NUM_CORES  = 4,
    parameter int DUR_W      = 8,
    parameter int AGE_W      = 4,
    parameter int AGE_LIMIT  = 12,
    localparam int LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sched_en,
    input  logic [NUM_LEVELS-1:0]       head_valid,
    input  logic [NUM_LEVELS*DUR_W-1:0] head_duration,
    output logic [NUM_LEVELS-1:0]       pop,
    input  logic [NUM_CORES-1:0]        core_done,
    output logic                        dispatch_valid,
    output logic [CORE_W-1:0]           dispatch_core,
    output logic [DUR_W-1:0]            dispatch_duration,
    output logic [LVL_W-1:0]            dispatch_level,
    output logic [NUM_CORES-1:0]        core_busy,
    output logic [15:0]                 dispatch_count
);

    localparam logic [AGE_W-1:0] AGE_LIMIT_C = AGE_W'(AGE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_MAX_C   = {AGE_W{1'b1}};

    // State registers
    logic [AGE_W-1:0]     age_q [NUM_LEVELS];
    logic [AGE_W-1:0]     age_d [NUM_LEVELS];
    logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
    logic                 dispatch_valid_q, dispatch_valid_d;
    logic [CORE_W-1:0]    dispatch_core_q, dispatch_core_d;
    logic [DUR_W-1:0]     dispatch_duration_q, dispatch_duration_d;
    logic [LVL_W-1:0]     dispatch_level_q, dispatch_level_d;
    logic [15:0]          dispatch_count_q, dispatch_count_d;

    // Selection signals
    logic                 starved_any_s;
    logic [LVL_W-1:0]     starved_lvl_s;
    logic [LVL_W-1:0]     valid_lvl_s;
    logic [LVL_W-1:0]     sel_lvl_s;
    logic [CORE_W-1:0]    sel_core_s;
    logic [DUR_W-1:0]     sel_dur_s;
    logic                 eligible_s;
    logic [NUM_CORES-1:0] core_set_s;

    // Pick the level to serve, the core to bind and decide eligibility.
    always_comb begin
        starved_any_s = 1'b0;
        starved_lvl_s = '0;
        valid_lvl_s   = '0;
        sel_core_s    = '0;
        // Ascending scan: the last hit is the highest index.
        for (int l = 0; l < NUM_LEVELS; l++) begin
            valid_lvl_s   = head_valid[l] ? LVL_W'(l) : valid_lvl_s;
            starved_lvl_s = (head_valid[l] && (age_q[l] >= AGE_LIMIT_C)) ? LVL_W'(l) : starved_lvl_s;
            starved_any_s = starved_any_s | (head_valid[l] && (age_q[l] >= AGE_LIMIT_C));
        end
        // Descending scan: the last hit is the lowest index.
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            sel_core_s = !core_busy_q[c] ? CORE_W'(c) : sel_core_s;
        end
        sel_lvl_s  = starved_any_s ? starved_lvl_s : valid_lvl_s;
        sel_dur_s  = head_duration[sel_lvl_s*DUR_W +: DUR_W];
        // Registered occupancy only; a core freed this edge counts from next cycle.
        eligible_s = !reset && sched_en && (|head_valid) && !(&core_busy_q);
        pop        = eligible_s ? (NUM_LEVELS'(1) << sel_lvl_s) : '0;
        core_set_s = eligible_s ? (NUM_CORES'(1) << sel_core_s) : '0;
    end

    // Next-state for ages, occupancy, dispatch command and counter.
    always_comb begin
        for (int l = 0; l < NUM_LEVELS; l++) begin
            age_d[l] = age_q[l];
            if (!sched_en) begin
                age_d[l] = age_q[l];
            end else if (pop[l]) begin
                age_d[l] = '0;
            end else if (head_valid[l]) begin
                age_d[l] = (age_q[l] == AGE_MAX_C) ? age_q[l] : age_q[l] + AGE_W'(1);
            end else begin
                age_d[l] = '0;
            end
        end
        // A dispatch never targets a busy core, so set and clear never collide.
        core_busy_d      = (core_busy_q & ~core_done) | core_set_s;
        dispatch_valid_d = eligible_s;
        if (eligible_s) begin
            dispatch_core_d     = sel_core_s;
            dispatch_duration_d = sel_dur_s;
            dispatch_level_d    = sel_lvl_s;
            dispatch_count_d    = dispatch_count_q + 16'd1;
        end else begin
            dispatch_core_d     = dispatch_core_q;
            dispatch_duration_d = dispatch_duration_q;
            dispatch_level_d    = dispatch_level_q;
            dispatch_count_d    = dispatch_count_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_LEVELS; l++) begin
                age_q[l] <= '0;
            end
            core_busy_q         <= '0;
            dispatch_valid_q    <= 1'b0;
            dispatch_core_q     <= '0;
            dispatch_duration_q <= '0;
            dispatch_level_q    <= '0;
            dispatch_count_q    <= 16'd0;
        end else begin
            for (int l = 0; l < NUM_LEVELS; l++) begin
                age_q[l] <= age_d[l];
            end
            core_busy_q         <= core_busy_d;
            dispatch_valid_q    <= dispatch_valid_d;
            dispatch_core_q     <= dispatch_core_d;
            dispatch_duration_q <= dispatch_duration_d;
            dispatch_level_q    <= dispatch_level_d;
            dispatch_count_q    <= dispatch_count_d;
        end
    end

    assign core_busy         = core_busy_q;
    assign dispatch_valid    = dispatch_valid_q;
    assign dispatch_core     = dispatch_core_q;
    assign dispatch_duration = dispatch_duration_q;
    assign dispatch_level    = dispatch_level_q;
    assign dispatch_count    = dispatch_count_q;

endmodule

// File: tb/tb_priority_dispatch_arbiter.sv
// Self-checking bench for priority_dispatch_arbiter: directed scenarios
// plus a random phase, checked against a behavioural reference model and a
// dispatch scoreboard.
module tb_priority_dispatch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_en;
    logic [3:0]  head_valid;
    logic [31:0] head_duration;
    logic [3:0]  pop;
    logic [3:0]  core_done;
    logic        dispatch_valid;
    logic [1:0]  dispatch_core;
    logic [7:0]  dispatch_duration;
    logic [1:0]  dispatch_level;
    logic [3:0]  core_busy;
    logic [15:0] dispatch_count;

    priority_dispatch_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .sched_en          (sched_en),
        .head_valid        (head_valid),
        .head_duration     (head_duration),
        .pop               (pop),
        .core_done         (core_done),
        .dispatch_valid    (dispatch_valid),
        .dispatch_core     (dispatch_core),
        .dispatch_duration (dispatch_duration),
        .dispatch_level    (dispatch_level),
        .core_busy         (core_busy),
        .dispatch_count    (dispatch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0]  m_busy  = 4'b0000;
    int          m_age [4];
    logic [15:0] m_count = 16'd0;
    logic [11:0] sb_q [$];   // {core, level, duration}
    logic [3:0]  obs_pop;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check pop before the edge, update the
    // model at the edge, check registered outputs just after it.
    task automatic step(input logic rst, input logic en, input logic [3:0] hv, input logic [3:0] done);
        bit         elig;
        int         sel;
        int         core;
        logic [3:0] e_pop;
        logic [11:0] ent;
        reset      = rst;
        sched_en   = en;
        head_valid = hv;
        core_done  = done;
        @(negedge clk);
        elig = !rst && en && (hv != 4'b0000) && (m_busy != 4'b1111);
        sel = -1;
        for (int l = 3; l >= 0; l--)
            if (sel < 0 && hv[l] && m_age[l] >= 12) sel = l;
        if (sel < 0)
            for (int l = 3; l >= 0; l--)
                if (sel < 0 && hv[l]) sel = l;
        core = -1;
        for (int c = 0; c < 4; c++)
            if (core < 0 && !m_busy[c]) core = c;
        e_pop = 4'b0000;
        if (elig) begin
            e_pop[sel] = 1'b1;
            ent = {2'(core), 2'(sel), head_duration[sel*8 +: 8]};
            sb_q.push_back(ent);
        end
        obs_pop = pop;
        check_val("pop", {28'd0, pop}, {28'd0, e_pop});
        @(posedge clk);
        if (rst) begin
            m_busy  = 4'b0000;
            m_count = 16'd0;
            for (int l = 0; l < 4; l++) m_age[l] = 0;
        end else begin
            m_busy = m_busy & ~done;
            if (elig) begin
                m_busy[core] = 1'b1;
                m_count      = m_count + 16'd1;
            end
            if (en)
                for (int l = 0; l < 4; l++) begin
                    if (elig && l == sel) m_age[l] = 0;
                    else if (hv[l])       m_age[l] = (m_age[l] == 15) ? 15 : m_age[l] + 1;
                    else                  m_age[l] = 0;
                end
        end
        #1;
        check_val("dispatch_valid", {31'd0, dispatch_valid}, {31'd0, (sb_q.size() > 0)});
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            if (dispatch_valid)
                check_val("dispatch_cmd", {20'd0, dispatch_core, dispatch_level, dispatch_duration}, {20'd0, ent});
        end
        check_val("core_busy", {28'd0, core_busy}, {28'd0, m_busy});
        check_val("dispatch_count", {16'd0, dispatch_count}, {16'd0, m_count});
        if (rst)
            check_val("reset_cmd", {20'd0, dispatch_core, dispatch_level, dispatch_duration}, 32'd0);
    endtask

    initial begin
        for (int l = 0; l < 4; l++) m_age[l] = 0;
        reset = 1'b1; sched_en = 1'b0; head_valid = 4'b0000; core_done = 4'b0000;
        // L3=20, L2=7, L1=5, L0=3
        head_duration = {8'd20, 8'd7, 8'd5, 8'd3};

        // Reset
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        check_val("rst_busy", {28'd0, core_busy}, 32'd0);
        check_val("rst_dv", {31'd0, dispatch_valid}, 32'd0);

        // First dispatch: L3 wins over L1, lands on core 0
        step(1'b0, 1'b1, 4'b1010, 4'b0000);
        check_val("s1_pop", {28'd0, obs_pop}, 32'h8);
        check_val("s1_cmd", {20'd0, dispatch_core, dispatch_level, dispatch_duration}, {20'd0, 2'd0, 2'd3, 8'd20});
        check_val("s1_busy", {28'd0, core_busy}, 32'h1);

        // Fill all four cores in order from reset
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'b1111, 4'b0000);
            check_val("fill_core", {30'd0, dispatch_core}, i);
        end
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_val("full_pop", {28'd0, obs_pop}, 32'h0);
        check_val("full_busy", {28'd0, core_busy}, 32'hF);
        check_val("full_count", {16'd0, dispatch_count}, 32'd4);

        // Free core 2: pop the cycle after, dispatch reports core 2
        step(1'b0, 1'b1, 4'b1111, 4'b0100);
        check_val("free_nopop", {28'd0, obs_pop}, 32'h0);
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_val("free_pop", {28'd0, obs_pop}, 32'h8);
        check_val("free_core", {30'd0, dispatch_core}, 32'd2);
        check_val("free_dv", {31'd0, dispatch_valid}, 32'd1);

        // Reset while all busy and a dispatch is visible
        step(1'b1, 1'b1, 4'b1111, 4'b0000);
        check_val("midrst_count", {16'd0, dispatch_count}, 32'd0);
        check_val("midrst_busy", {28'd0, core_busy}, 32'd0);

        // Starvation: L0 wins after 12 denied grants, then L3 again
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 4'b1001, m_busy);
            check_val("starve_pop", {28'd0, obs_pop}, (i == 12) ? 32'h1 : 32'h8);
        end

        // sched_en low freezes ages; starvation resumes where it left off
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b1001, m_busy);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'b1111, 4'b0000);
            check_val("dis_pop", {28'd0, obs_pop}, 32'h0);
            check_val("dis_dv", {31'd0, dispatch_valid}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'b1001, m_busy);
            check_val("reen_pop", {28'd0, obs_pop}, (i == 6) ? 32'h1 : 32'h8);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            head_duration = $urandom;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                 4'($urandom), 4'($urandom) & 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_dispatch_arbiter.md
Name: priority_dispatch_arbiter

Overview:
- Arbitrates between the per-priority task queue heads and the pool of execution cores.
- Each cycle it selects at most one waiting task by priority, with aging-based anti-starvation, and binds it to the lowest-index free core.
- Emits a registered dispatch command to that core and tracks core occupancy from core completion pulses.
- Sits between the priority queue storage and the core countdown datapath.

Parameters:
- NUM_LEVELS, 4, number of priority levels; level NUM_LEVELS-1 is highest.
- NUM_CORES, 4, number of execution cores.
- DUR_W, 8, task duration width in cycles.
- AGE_W, 4, width of the per-level aging counter.
- AGE_LIMIT, 12, wait cycles after which a level is treated as starved; must be < 2^AGE_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- sched_en  in  1  enables dispatch; when low no pops occur and ages hold.
- head_valid  in  NUM_LEVELS  bit L=1: queue L has a task at its head.
- head_duration  in  NUM_LEVELS*DUR_W  head duration of level L in bits [L*DUR_W +: DUR_W].
- pop  out  NUM_LEVELS  one-hot or zero; combinational; queue L pops its head at this edge.
- core_done  in  NUM_CORES  one-cycle pulse per core on task completion.
- dispatch_valid  out  1  registered; one-cycle dispatch strobe.
- dispatch_core  out  $clog2(NUM_CORES)  target core of the dispatch.
- dispatch_duration  out  DUR_W  duration of the dispatched task.
- dispatch_level  out  $clog2(NUM_LEVELS)  source level of the dispatched task.
- core_busy  out  NUM_CORES  registered occupancy per core.
- dispatch_count  out  16  total dispatches; wraps at 2^16.

Behaviour:
- Reset (synchronous, at clk edge while reset=1): core_busy=0, all ages=0, dispatch_valid=0, dispatch_core/duration/level=0, dispatch_count=0. pop=0 while reset=1. Reset mid-operation discards in-flight tracking; cores are externally reset in the same cycle.
- Eligibility: sched_en=1, at least one head_valid bit set, and at least one core_busy bit clear.
  - Uses registered core_busy only; no bypass of same-cycle core_done.
- Level selection:
  - If any valid level has age >= AGE_LIMIT (starved), pick the highest-index starved level.
  - Otherwise pick the highest-index valid level.
- Core selection: lowest-index core with core_busy=0.
- pop[sel]=1 combinationally in the eligible cycle; zero otherwise.
- At the same edge:
  - dispatch_valid<=1; dispatch_core/duration/level capture the selection.
  - core_busy[core]<=1.
  - dispatch_count increments.
- dispatch_valid is low in any cycle after a non-eligible cycle. Dispatch latency is 1 cycle after pop.
- Aging, per level each enabled cycle:
  - granted: age<=0.
  - valid and not granted: age<=age+1, saturating at 2^AGE_W-1.
  - not valid: age<=0.
  - When sched_en=0, ages hold.
- core_done[c]=1 clears core_busy[c] at that edge. Dispatch to a busy core cannot occur, so set/clear never conflict on one core. A core freed at edge N is eligible from cycle N+1.
- core_done on an already-free core is ignored.
- A duration of 0 is dispatched unchanged; handling it is the core's concern.
- At most one dispatch per cycle regardless of free-core count.

Test Plan:
- Reset, then head_valid=4'b1010, durations L3=20, L1=5, all cores free -> cycle0 pop=4'b1000; cycle1 dispatch_valid=1, core=0, level=3, duration=20, core_busy=4'b0001.
- Hold head_valid=4'b1111 for 4 cycles with no core_done -> pops L3 each cycle; cores 0,1,2,3 bound in order; then pop=0, core_busy=4'b1111, dispatch_count=4.
- All cores busy, pulse core_done=4'b0100 at edge N -> cycle N+1 pop asserted, and the dispatch at N+2 reports dispatch_core=2.
- head_valid=4'b1001 continuously, one core cycling free every cycle -> L0 age reaches 12 after 12 denied grants; next grant goes to L0 (pop=4'b0001); its age returns to 0 and L3 wins again.
- sched_en=0 with head_valid=4'b1111 and free cores -> pop=0, no dispatch, ages unchanged; re-enable -> normal grant the next cycle.
- Assert reset while core_busy=4'b1111 and dispatch_valid=1 -> after that edge all outputs are 0 and dispatch_count=0.
